pc_fetch_unit: RTL and testbench

Instruction-fetch front end for the monocycle CPU. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into a registered fetch buffer with a valid/ready handshake toward decode. It resolves next-PC redirects for branch, jump, jr, exception entry and eret, and holds the exception PC.

---
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the word-addressed PC, registers the fetched
// instruction toward decode, and resolves branch/jump/jr/exception/eret redirects.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] EXC_VECTOR = 32'd20
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid,
    input  logic        id_ready,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        eret,
    input  logic        exc_req,
    output logic [31:0] link_pc,
    output logic [31:0] epc,
    output logic [1:0]  dbg_state_o
);

    // Handshake: if_inst/if_pc are consumed by decode on a rising edge where
    // if_valid && id_ready; while if_valid && !id_ready they are held unchanged.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_inst_q;
    logic [31:0] if_pc_q;
    logic        if_valid_q;
    logic [31:0] epc_q;

    logic [31:0] link_pc_c;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] redir_tgt;
    logic [31:0] exc_epc;
    logic        cf_redir;
    logic        take_exc;
    logic        stall;

    always_comb begin
        link_pc_c  = if_pc_q + 32'd1;
        branch_tgt = link_pc_c + {{16{if_inst_q[15]}}, if_inst_q[15:0]};
        jump_tgt   = {link_pc_c[31:26], if_inst_q[25:0]};
        cf_redir   = if_valid_q && (eret || jr || jump || branch_taken);
        take_exc   = exc_req && (state_q != ST_BOOT);
        stall      = if_valid_q && !id_ready;
        // The oldest instruction not yet executed is either the one held in the
        // fetch buffer or, during a bubble, the one about to be fetched.
        exc_epc    = if_valid_q ? if_pc_q : pc_q;
        redir_tgt  = branch_tgt;
        if (eret) begin
            redir_tgt = epc_q;
        end else if (jr) begin
            redir_tgt = jr_addr;
        end else if (jump) begin
            redir_tgt = jump_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            if_inst_q  <= 32'd0;
            if_pc_q    <= 32'd0;
            if_valid_q <= 1'b0;
            epc_q      <= 32'd0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if_inst_q  <= inst_data;
                    if_pc_q    <= pc_q;
                    pc_q       <= pc_q + 32'd1;
                    if_valid_q <= 1'b1;
                    state_q    <= ST_RUN;
                end
                ST_RUN: begin
                    if (take_exc) begin
                        epc_q      <= exc_epc;
                        pc_q       <= EXC_VECTOR;
                        if_valid_q <= 1'b0;
                        state_q    <= ST_REDIR;
                    end else if (cf_redir) begin
                        pc_q       <= redir_tgt;
                        if_valid_q <= 1'b0;
                        state_q    <= ST_REDIR;
                    end else if (!stall) begin
                        if_inst_q  <= inst_data;
                        if_pc_q    <= pc_q;
                        pc_q       <= pc_q + 32'd1;
                        if_valid_q <= 1'b1;
                    end
                end
                ST_REDIR: begin
                    if (take_exc) begin
                        epc_q      <= exc_epc;
                        pc_q       <= EXC_VECTOR;
                        if_valid_q <= 1'b0;
                    end else begin
                        if_inst_q  <= inst_data;
                        if_pc_q    <= pc_q;
                        pc_q       <= pc_q + 32'd1;
                        if_valid_q <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    pc_q       <= RESET_PC;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_addr     = pc_q;
    assign if_inst     = if_inst_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign link_pc     = link_pc_c;
    assign epc         = epc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: an instruction-stream reference model predicts every
// delivered {pc, inst}; a decoupled monitor pops and compares at each handshake.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] EXC_VEC  = 32'd20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_addr;
    logic [31:0] inst_data;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = 32'd0;
    logic        eret = 1'b0;
    logic        exc_req = 1'b0;
    logic [31:0] link_pc;
    logic [31:0] epc;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .inst_data(inst_data),
        .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid), .id_ready(id_ready),
        .branch_taken(branch_taken), .jump(jump), .jr(jr), .jr_addr(jr_addr),
        .eret(eret), .exc_req(exc_req), .link_pc(link_pc), .epc(epc),
        .dbg_state_o(dbg_state)
    );

    // Instruction memory: a small table, with a hashed word for higher addresses.
    logic [31:0] mem [0:63];

    function automatic logic [31:0] hash_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd64) return mem[a[5:0]];
        return hash_word(a);
    endfunction

    assign inst_data = (pc_addr < 32'd64) ? mem[pc_addr[5:0]] : hash_word(pc_addr);

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    // Reference model: what decode currently sees and where fetch will read next.
    logic        m_started;
    logic        m_valid;
    logic [31:0] m_pres;
    logic [31:0] m_fetch;
    logic [31:0] m_epc;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_valid   = 1'b0;
        m_pres    = 32'd0;
        m_fetch   = RESET_PC;
        m_epc     = 32'd0;
        exp_q.delete();
    endtask

    // One clock of stimulus; predicts the result of the coming edge from the rules.
    task automatic step(input logic rdy, input logic br, input logic jmp, input logic jrr,
                        input logic er, input logic exc, input logic [31:0] ja);
        logic        n_started, n_valid, push;
        logic [31:0] n_pres, n_fetch, n_epc, inst, ret, tgt;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        id_ready = rdy; branch_taken = br; jump = jmp; jr = jrr;
        eret = er; exc_req = exc; jr_addr = ja;
        n_started = m_started; n_valid = m_valid; n_pres = m_pres;
        n_fetch = m_fetch; n_epc = m_epc; push = 1'b0;
        inst = mem_word(m_pres);
        ret  = m_pres + 32'd1;
        if (!m_started) begin
            n_started = 1'b1; n_valid = 1'b1; n_pres = m_fetch;
            n_fetch = m_fetch + 32'd1; push = 1'b1;
        end else if (exc) begin
            n_epc = m_valid ? m_pres : m_fetch;
            n_fetch = EXC_VEC; n_valid = 1'b0;
        end else if (m_valid && (er || jrr || jmp || br)) begin
            if (er) tgt = m_epc;
            else if (jrr) tgt = ja;
            else if (jmp) tgt = {ret[31:26], inst[25:0]};
            else tgt = ret + {{16{inst[15]}}, inst[15:0]};
            n_fetch = tgt; n_valid = 1'b0;
        end else if (!(m_valid && !rdy)) begin
            n_valid = 1'b1; n_pres = m_fetch; n_fetch = m_fetch + 32'd1; push = 1'b1;
        end
        @(posedge clk);
        #1;
        m_started = n_started; m_valid = n_valid; m_pres = n_pres;
        m_fetch = n_fetch; m_epc = n_epc;
        if (push) exp_q.push_back({n_pres, mem_word(n_pres)});
    endtask

    task automatic advance();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic run_to(input logic [31:0] addr);
        int n = 0;
        while (!(m_valid && m_pres == addr) && n < 100) begin
            advance();
            n++;
        end
        tests++;
        if (!(m_valid && m_pres == addr)) begin
            fails++;
            $display("FAIL run_to: never reached if_pc %h within 100 cycles", addr);
        end
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                 32'($urandom_range(0, 80)));
        end
    endtask

    task automatic check_reset_values();
        check32("rst_pc_addr", pc_addr, RESET_PC);
        check32("rst_if_inst", if_inst, 32'd0);
        check32("rst_if_pc", if_pc, 32'd0);
        check32("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check32("rst_epc", epc, 32'd0);
        check32("rst_link_pc", link_pc, 32'd1);
    endtask

    // Monitor: compares visible state every cycle and pops the scoreboard whenever
    // the held instruction leaves the fetch buffer at the coming edge.
    logic mon_en = 1'b0;
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && rst_n) begin
                check32("pc_addr", pc_addr, m_fetch);
                check32("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
                check32("epc", epc, m_epc);
                check32("link_pc", link_pc, m_pres + 32'd1);
                if (m_valid) check32("if_pc", if_pc, m_pres);
                if (if_valid && (id_ready || exc_req || eret || jr || jump || branch_taken)) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_underflow: got if_pc %h with nothing expected", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check32("sb_if_pc", if_pc, e[63:32]);
                        check32("sb_if_inst", if_inst, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[13] = {mem[13][31:16], 16'hFFFE};
        mem[21] = {mem[21][31:16], 16'd5};
        model_reset();
        mon_en = 1'b1;
        #1;
        check_reset_values();

        advance();
        check32("boot_if_pc", if_pc, RESET_PC);
        check32("boot_if_inst", if_inst, mem[0]);
        check32("boot_pc_addr", pc_addr, RESET_PC + 32'd1);

        run_to(32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            check32("stall_if_pc", if_pc, 32'd4);
            check32("stall_if_inst", if_inst, mem[4]);
            check32("stall_pc_addr", pc_addr, 32'd5);
        end
        advance();
        check32("release_if_pc", if_pc, 32'd5);

        run_to(32'd13);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check32("br_bubble", {31'd0, if_valid}, 32'd0);
        advance();
        check32("br_target", if_pc, 32'd12);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd19);
        advance();
        check32("jr_target", if_pc, 32'd19);

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8);
        advance();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        check32("exc_epc", epc, 32'd8);
        check32("exc_bubble", {31'd0, if_valid}, 32'd0);
        advance();
        check32("exc_vector", if_pc, EXC_VEC);
        advance();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        advance();
        check32("eret_target", if_pc, 32'd8);

        advance();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd40);
        advance();
        check32("exc_over_jr_pc", if_pc, EXC_VEC);
        check32("exc_over_jr_epc", epc, 32'd9);

        advance();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        check32("redir_exc_epc", epc, 32'd27);
        advance();
        check32("redir_exc_pc", if_pc, EXC_VEC);

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        advance();
        check32("wrap_if_pc", if_pc, 32'hFFFF_FFFF);
        check32("wrap_pc_addr", pc_addr, 32'd0);
        advance();
        check32("wrap_next", if_pc, 32'd0);

        random_steps(400);

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1;
        advance();
        check32("rerun_if_pc", if_pc, RESET_PC);

        random_steps(200);

        check32("sb_leftover", exp_q.size(), {31'd0, m_valid});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
